// File: rtl/led_frame_shifter_if.sv
// Frame handshake between the frame register (master) and led_frame_shifter (slave).
interface led_frame_shifter_if #(
    parameter int WIDTH = 30
) ();
    logic             in_val;
    logic             in_rdy;
    logic [WIDTH-1:0] in_data;

    modport master (
        output in_val,
        output in_data,
        input  in_rdy
    );

    modport slave (
        input  in_val,
        input  in_data,
        output in_rdy
    );
endinterface

// File: rtl/led_frame_shifter.sv
// LED frame serializer: accepts a WIDTH-bit frame, shifts it out MSB-first on a
// divided serial clock, then pulses latch for LATCH_CYCLES clk cycles.
module led_frame_shifter #(
    parameter int WIDTH        = 30,
    parameter int CLK_DIV      = 4,
    parameter int LATCH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    led_frame_shifter_if.slave  bus,
    output logic                sclk,
    output logic                sdo,
    output logic                latch,
    output logic                busy
);

    localparam int BIT_W = $clog2(WIDTH + 1);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int LAT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

    localparam logic [BIT_W-1:0] BIT_FULL = BIT_W'(WIDTH);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } state_t;

    state_t           state,   state_n;
    logic [WIDTH-1:0] shreg,   shreg_n;
    logic [BIT_W-1:0] bit_cnt, bit_cnt_n;
    logic [DIV_W-1:0] div_cnt, div_cnt_n;
    logic             phase,   phase_n;     // 0: sclk-low half, 1: sclk-high half
    logic [LAT_W-1:0] lat_cnt, lat_cnt_n;

    // State and datapath registers; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            phase   <= 1'b0;
            lat_cnt <= '0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            bit_cnt <= bit_cnt_n;
            div_cnt <= div_cnt_n;
            phase   <= phase_n;
            lat_cnt <= lat_cnt_n;
        end
    end

    // Next-state and datapath update: divider paces each half bit, shift on high-phase end.
    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        div_cnt_n = div_cnt;
        phase_n   = phase;
        lat_cnt_n = lat_cnt;
        unique case (state)
            IDLE: begin
                if (bus.in_val) begin
                    shreg_n   = bus.in_data;
                    bit_cnt_n = BIT_FULL;
                    div_cnt_n = '0;
                    phase_n   = 1'b0;
                    state_n   = SHIFT;
                end
            end
            SHIFT: begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt_n = '0;
                    if (!phase) begin
                        phase_n = 1'b1;
                    end else begin
                        phase_n   = 1'b0;
                        shreg_n   = {shreg[WIDTH-2:0], 1'b0};
                        bit_cnt_n = bit_cnt - BIT_ONE;
                        if (bit_cnt == BIT_ONE) begin
                            lat_cnt_n = '0;
                            state_n   = LATCH;
                        end
                    end
                end else begin
                    div_cnt_n = div_cnt + DIV_W'(1);
                end
            end
            LATCH: begin
                if (lat_cnt == LAT_LAST) begin
                    state_n = IDLE;
                end else begin
                    lat_cnt_n = lat_cnt + LAT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs decoded from registered state only.
    assign bus.in_rdy = (state == IDLE);
    assign busy       = (state != IDLE);
    assign sclk       = (state == SHIFT) && phase;
    assign sdo        = (state == SHIFT) ? shreg[WIDTH-1] : 1'b0;
    assign latch      = (state == LATCH);

endmodule

// File: doc/led_frame_shifter.md
Name: led_frame_shifter

Overview:
- Downstream consumer of the 30-bit frame register output.
- Accepts a 30-bit LED frame (3 x 10-bit channel intensities) over a valid/ready handshake.
- Shifts the frame out MSB-first on a divided serial clock, then pulses a latch strobe so the external LED driver commits the frame.
- Sits between the frame register and the board-level LED driver pins.

Parameters:
WIDTH, 30, frame width in bits; must be >= 2.
CLK_DIV, 4, clk cycles per sclk half-period; must be >= 1.
LATCH_CYCLES, 2, width of the latch pulse in clk cycles; must be >= 1.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
in_val  input  1  frame valid from upstream.
in_rdy  output  1  block can accept a frame; high only in IDLE.
in_data  input  WIDTH  frame to shift out; sampled only on an accepted handshake.
sclk  output  1  serial clock to the LED driver.
sdo  output  1  serial data; stable while sclk is high.
latch  output  1  frame-commit strobe.
busy  output  1  high from the cycle after accept until the return to IDLE.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst. All outputs are registered, or decoded from registered state only; there are no combinational paths from inputs to outputs.
- Reset values, visible in the cycle after rst is sampled high: state=IDLE, in_rdy=1, sclk=0, sdo=0, latch=0, busy=0. Shift register and counters are cleared.
- Handshake: a transfer occurs on a rising edge where in_val && in_rdy.
  - in_val while busy is ignored; upstream holds in_val/in_data until accepted.
  - in_data changes after accept have no effect.
- FSM: IDLE -> SHIFT -> LATCH -> IDLE.
- IDLE:
  - in_rdy=1, busy=0, sclk=0, sdo=0, latch=0.
  - On accept: load the shift register with in_data, set the bit counter to WIDTH, clear the divider, go to SHIFT.
- SHIFT:
  - in_rdy=0, busy=1.
  - sdo = shift-register MSB, valid from the first SHIFT cycle.
  - Each bit occupies 2*CLK_DIV cycles: CLK_DIV cycles with sclk=0, then CLK_DIV cycles with sclk=1.
  - At the end of the high phase: sclk returns to 0, the shift register shifts left by 1, and the bit counter decrements.
  - sdo changes only while sclk=0, so the receiver samples on the sclk rising edge.
  - Exactly WIDTH sclk rising edges per frame.
  - After the last bit's high phase, go to LATCH.
  - The first sclk rise occurs CLK_DIV cycles after the first SHIFT cycle.
- LATCH:
  - sclk=0, sdo=0, latch=1 for exactly LATCH_CYCLES cycles, then IDLE.
  - in_rdy rises in the first IDLE cycle after latch falls.
- Timing:
  - busy duration = WIDTH*2*CLK_DIV + LATCH_CYCLES cycles; 242 at defaults.
  - With in_val held high continuously, frames are separated by exactly 1 IDLE cycle.
- Reset mid-operation (SHIFT or LATCH): abort immediately. The next cycle shows the reset values, no latch pulse is emitted, and the partial frame is discarded.
- Reset and in_val together: reset wins; no frame is accepted.
- Counter widths: bit counter is $clog2(WIDTH+1) bits; divider is $clog2(CLK_DIV) bits, minimum 1. No wrap-around is permitted mid-frame.

Test Plan:
1. Reset: rst=1 for 2 cycles with in_val=1 -> after reset in_rdy=1, sclk=0, sdo=0, latch=0, busy=0; no frame accepted.
2. Single frame: in_data=30'h2AAAAAAA, defaults -> 30 sclk rises; sdo sampled on the rises = 1,0,1,0,... MSB-first matching in_data; latch high for exactly 2 cycles after the last sclk fall; busy high for 242 cycles.
3. Backpressure: during frame 30'h2AAAAAAA, drive in_val=1 with 30'h00000001 -> not accepted until in_rdy=1; second frame captures 29 zeros then a 1; first frame unaffected.
4. Reset mid-frame: assert rst for 1 cycle after the 10th sclk rise -> next cycle all outputs at reset values, no latch pulse; then frame 30'h3FFFFFFF shifts all 30 ones followed by one latch pulse.
5. Streaming: 50 $urandom 30-bit frames with in_val held high -> each captured frame equals its driven value; 50 latch pulses; exactly 1 IDLE cycle between frames.
6. Parameter corner: CLK_DIV=1, LATCH_CYCLES=1, in_data=30'h15555555 -> sclk toggles every cycle; captured frame equals 30'h15555555; busy for 61 cycles.
